// File: rtl/pipe_interc_pkg.sv
// Shared definitions for the pipelined interconnect: skid-stage state encoding,
// depth limit and the occupancy-width helper.
package pipe_interc_pkg;

    localparam int unsigned MAX_DEPTH = 8;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } stage_state_e;

    // Occupancy spans 0..2*depth; a zero-depth wire still gets a 1-bit port.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_interc_stage.sv
// One elastic skid stage: main + skid register, registered upstream ready,
// so no combinational ready path crosses the stage.
module pipe_interc_stage
    import pipe_interc_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    output logic [WIDTH-1:0] dn_data_o,
    output logic             dn_valid_o,
    input  logic             dn_ready_i
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
    logic             push, pop;

    assign push = up_valid_i & ready_q;
    assign pop  = (state_q != StEmpty) & dn_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    main_d  = up_data_i;
                end
            end
            StOne: begin
                if (push && pop) begin
                    main_d = up_data_i;
                end else if (push) begin
                    state_d = StFull;
                    skid_d  = up_data_i;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // ready_q is low here, so only a pop can happen.
                if (pop) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != StFull);
        end
    end

    assign up_ready_o = ready_q;
    assign dn_valid_o = (state_q != StEmpty);
    assign dn_data_o  = main_q;

endmodule

// File: rtl/pipe_interc.sv
// WIDTH-bit valid/ready interconnect retimed through DEPTH skid stages, with an
// occupancy counter; DEPTH=0 is a plain combinational connection.
module pipe_interc
    import pipe_interc_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;

        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign occupancy = '0;
    end else begin : g_pipe
        logic [WIDTH-1:0] data_w  [DEPTH+1];
        logic             valid_w [DEPTH+1];
        logic             ready_w [DEPTH+1];
        logic [CNT_W-1:0] occ_q, occ_d;
        logic             in_xfer, out_xfer;

        assign data_w[0]      = in_data;
        assign valid_w[0]     = in_valid;
        assign in_ready       = ready_w[0];
        assign out_data       = data_w[DEPTH];
        assign out_valid      = valid_w[DEPTH];
        assign ready_w[DEPTH] = out_ready;

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            pipe_interc_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk_i     (clk),
                .reset_i   (reset),
                .up_data_i (data_w[i]),
                .up_valid_i(valid_w[i]),
                .up_ready_o(ready_w[i]),
                .dn_data_o (data_w[i+1]),
                .dn_valid_o(valid_w[i+1]),
                .dn_ready_i(ready_w[i+1])
            );
        end

        // Transfers between stages conserve the count, so only the ends matter.
        assign in_xfer  = in_valid & ready_w[0];
        assign out_xfer = valid_w[DEPTH] & out_ready;

        always_comb begin
            occ_d = occ_q;
            if (in_xfer && !out_xfer) begin
                occ_d = occ_q + CNT_W'(1);
            end else if (!in_xfer && out_xfer) begin
                occ_d = occ_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
    end

endmodule
